// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and a constant-foldable clog2 used to size the bit counter.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// Requester-side bundle of the serial adder: start/done handshake, operands
// and registered results.
interface serial_add_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );

endinterface

// File: rtl/fa_v1.sv
// Single-bit full-adder cell, the only arithmetic in the serial datapath.
module fa_v1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_v1 cell walks a WIDTH-bit operand pair
// LSB first, one bit per clock, and reports sum, carry-out and overflow.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic        clk,
    input  logic        rst_n,
    serial_add_if.slave bus
);

    localparam int             CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 2);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             msb_cin;
    logic             c_out_q;
    logic             overflow_q;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             running;
    logic             busy_c;
    logic             done_c;

    fa_v1 u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign running = (state == ST_RUN);
    // A start in RUN is dropped silently; IDLE and DONE both accept.
    assign accept  = bus.start && !running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy_c = 1'b1;
                if (cnt == LAST_CNT) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_c     = 1'b1;
                state_next = bus.start ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a       <= '0;
            sh_b       <= '0;
            sum_q      <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            msb_cin    <= 1'b0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            sh_a       <= bus.a;
            sh_b       <= bus.b;
            carry      <= bus.c_in;
            cnt        <= '0;
            sum_q      <= '0;
            msb_cin    <= 1'b0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (running) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            sum_q <= {fa_s, sum_q[WIDTH-1:1]};
            carry <= fa_co;
            // Counter holds on the last bit so it never wraps mid-operation.
            if (cnt != LAST_CNT) cnt <= cnt + CNT_W'(1);
            if (cnt == MSB_CNT) msb_cin <= fa_co;
            if (cnt == LAST_CNT) begin
                c_out_q    <= fa_co;
                overflow_q <= msb_cin ^ fa_co;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed operand pairs push expected
// results, a negedge monitor pops one entry per done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   edges;
    int   extra_done;
    exp_t exp_q[$];
    exp_t mon_e;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic [W-1:0] exp_sum,
                                  input logic exp_co, input logic exp_ovf,
                                  input bit push);
        exp_t e;
        @(posedge clk);
        #2;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        if (push) begin
            e.sum   = exp_sum;
            e.c_out = exp_co;
            e.ovf   = exp_ovf;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        if (!bus.done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    // Results are checked only here, whenever the DUT flags done.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending result at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("sum", bus.sum, mon_e.sum);
                check_output("c_out", bus.c_out, mon_e.c_out);
                check_output("overflow", bus.overflow, mon_e.ovf);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.c_in    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_sum", bus.sum, 0);
        check_output("reset_c_out", bus.c_out, 0);
        check_output("reset_overflow", bus.overflow, 0);
        rst_n = 1'b1;

        apply_stimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        check_output("busy_after_e0", bus.busy, 1);
        wait_done(edges);
        check_output("latency_edges", edges, W + 1);
        check_output("busy_in_done", bus.busy, 0);
        @(negedge clk);
        check_output("done_fell", bus.done, 0);

        apply_stimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_done(edges);
        check_output("latency_ff01", edges, W + 1);
        apply_stimulus(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done(edges);

        apply_stimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        wait_done(edges);
        apply_stimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_done(edges);

        // Start pulse landing on E3 of a running operation must be ignored.
        apply_stimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        wait_done(edges);
        check_output("run_start_total_edges", edges, W - 2);
        check_output("run_start_busy_in_done", bus.busy, 0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check_output("run_start_extra_done", extra_done, 0);

        // Back-to-back: start held in the DONE cycle.
        apply_stimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        wait_done(edges);
        check_output("b2b_first_latency", edges, W + 1);
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        mon_e.sum   = 8'h03;
        mon_e.c_out = 1'b0;
        mon_e.ovf   = 1'b0;
        exp_q.push_back(mon_e);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        check_output("b2b_done_one_cycle", bus.done, 0);
        check_output("b2b_busy", bus.busy, 1);
        check_output("b2b_sum_cleared", bus.sum, 0);
        wait_done(edges);
        check_output("b2b_second_done_edges", edges, W + 1);

        // Asynchronous reset mid-cycle after E4 discards the partial sum.
        apply_stimulus(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #5;
        check_output("partial_sum_e4", bus.sum, 8'h60);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_busy", bus.busy, 0);
        check_output("async_rst_done", bus.done, 0);
        check_output("async_rst_sum", bus.sum, 0);
        check_output("async_rst_c_out", bus.c_out, 0);
        check_output("async_rst_overflow", bus.overflow, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply_stimulus(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
        wait_done(edges);
        check_output("post_reset_latency", edges, W + 1);

        repeat (3) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
